// File: rtl/iob_mem_pkg.sv
// Shared constants and helpers for the byte-enabled two-port memory.
package iob_mem_pkg;

    localparam int unsigned RD_FIRST   = 0;
    localparam int unsigned WR_THROUGH = 1;

    // Widest word the merge helper handles; narrower words are zero-extended in and sliced out.
    localparam int unsigned MAX_DATA_W = 512;
    localparam int unsigned MAX_BYTES  = MAX_DATA_W / 8;

    function automatic int unsigned nbytes(input int unsigned data_w);
        return data_w / 8;
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(
        input logic [MAX_DATA_W-1:0] old_word,
        input logic [MAX_DATA_W-1:0] new_word,
        input logic [MAX_BYTES-1:0]  be
    );
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int unsigned i = 0; i < MAX_BYTES; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/iob_2p_mem_be_if.sv
// Write/read bus of the two-port memory; master drives requests, slave is the memory.
interface iob_2p_mem_be_if
    import iob_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 6
);

    logic                        w_port_en;
    logic [nbytes(DATA_W)-1:0]   w_en;
    logic [ADDR_W-1:0]           w_addr;
    logic [DATA_W-1:0]           data_in;
    logic                        r_port_en;
    logic [ADDR_W-1:0]           r_addr;
    logic [DATA_W-1:0]           data_out;
    logic                        r_valid;

    modport master (
        output w_port_en, w_en, w_addr, data_in, r_port_en, r_addr,
        input  data_out, r_valid
    );

    modport slave (
        input  w_port_en, w_en, w_addr, data_in, r_port_en, r_addr,
        output data_out, r_valid
    );

endinterface

// File: rtl/iob_mem_out_pipe.sv
// Read output stage: one or two data/valid register stages; data holds when no result arrives.
module iob_mem_out_pipe
    import iob_mem_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STAGES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    if (STAGES < 1 || STAGES > 2) begin : g_bad_stages
        $error("iob_mem_out_pipe: STAGES must be 1 or 2");
    end

    logic              r_vld1;
    logic [DATA_W-1:0] r_dat1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld1 <= 1'b0;
            r_dat1 <= '0;
        end else begin
            r_vld1 <= i_valid;
            if (i_valid) begin
                r_dat1 <= i_data;
            end
        end
    end

    if (STAGES == 2) begin : g_stage2
        logic              r_vld2;
        logic [DATA_W-1:0] r_dat2;

        // Stage 2 copies only real results, so later writes cannot disturb in-flight data.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_vld2 <= 1'b0;
                r_dat2 <= '0;
            end else begin
                r_vld2 <= r_vld1;
                if (r_vld1) begin
                    r_dat2 <= r_dat1;
                end
            end
        end

        assign o_valid = r_vld2;
        assign o_data  = r_dat2;
    end else begin : g_stage1
        assign o_valid = r_vld1;
        assign o_data  = r_dat1;
    end

endmodule

// File: rtl/iob_2p_mem_be.sv
// Simple dual-port RAM with byte write enables, 1- or 2-cycle read latency and
// selectable read-during-write policy.
module iob_2p_mem_be
    import iob_mem_pkg::*;
#(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned ADDR_W  = 6,
    parameter int unsigned OUT_REG = 0,
    parameter int unsigned RD_MODE = 0
) (
    input logic             clk,
    input logic             rst_n,
    iob_2p_mem_be_if.slave  bus
);

    localparam int unsigned NB    = nbytes(DATA_W);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    if ((DATA_W % 8) != 0 || DATA_W > MAX_DATA_W || OUT_REG > 1 || RD_MODE > 1)
    begin : g_bad_param
        $error("iob_2p_mem_be: illegal DATA_W, OUT_REG or RD_MODE");
    end

    logic [DATA_W-1:0] ram [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (bus.w_port_en) begin
            for (int unsigned i = 0; i < NB; i++) begin
                if (bus.w_en[i]) begin
                    ram[bus.w_addr][8*i +: 8] <= bus.data_in[8*i +: 8];
                end
            end
        end
    end

    logic              w_collide;
    logic [DATA_W-1:0] w_old;
    logic [DATA_W-1:0] w_rd_data;

    assign w_old     = ram[bus.r_addr];
    assign w_collide = bus.r_port_en & bus.w_port_en & (bus.r_addr == bus.w_addr);

    // The array read returns the pre-write word; write-through patches in the written bytes.
    always_comb begin
        w_rd_data = w_old;
        if (RD_MODE == WR_THROUGH && w_collide) begin
            w_rd_data = DATA_W'(byte_merge(MAX_DATA_W'(w_old), MAX_DATA_W'(bus.data_in),
                                           MAX_BYTES'(bus.w_en)));
        end
    end

    iob_mem_out_pipe #(
        .DATA_W (DATA_W),
        .STAGES (1 + OUT_REG)
    ) u_out_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (bus.r_port_en),
        .i_data  (w_rd_data),
        .o_valid (bus.r_valid),
        .o_data  (bus.data_out)
    );

endmodule

// File: tb/tb_iob_2p_mem_be.sv
// Bench: all four OUT_REG x RD_MODE builds share one stimulus and are checked each cycle
// against a word-array model plus hand-computed literals.
module tb_iob_2p_mem_be;

    localparam int unsigned DW   = 32;
    localparam int unsigned AW   = 4;
    localparam int unsigned NCFG = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_wpe = 1'b0;
    logic [3:0]  s_wen = '0;
    logic [3:0]  s_waddr = '0;
    logic [31:0] s_din = '0;
    logic        s_rpe = 1'b0;
    logic [3:0]  s_raddr = '0;

    logic [31:0]     dout [NCFG];
    logic [NCFG-1:0] rv;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    // Config g: OUT_REG = g/2, RD_MODE = g%2.
    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        iob_2p_mem_be_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
        assign bus.w_port_en = s_wpe;
        assign bus.w_en      = s_wen;
        assign bus.w_addr    = s_waddr;
        assign bus.data_in   = s_din;
        assign bus.r_port_en = s_rpe;
        assign bus.r_addr    = s_raddr;
        assign dout[g]       = bus.data_out;
        assign rv[g]         = bus.r_valid;

        iob_2p_mem_be #(
            .DATA_W  (DW),
            .ADDR_W  (AW),
            .OUT_REG (g / 2),
            .RD_MODE (g % 2)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );
    end

    // Model: memory words, per-byte "has been written" marks, expected output per config.
    logic [31:0]     mem [16];
    logic [3:0]      kn [16] = '{default: 4'h0};
    logic [NCFG-1:0] e_v = '0;
    logic [31:0]     e_d [NCFG] = '{default: 32'h0};
    logic [NCFG-1:0] e_k = '1;
    logic            p_req = 1'b0;
    logic [31:0]     p_d [2] = '{default: 32'h0};
    logic [1:0]      p_k = '0;

    task automatic model_reset();
        e_v   = '0;
        e_k   = '1;
        p_req = 1'b0;
        for (int g = 0; g < NCFG; g++) e_d[g] = 32'h0;
    endtask

    // Applies one clock edge of the current inputs to the model.
    task automatic model_step();
        logic [31:0] old_w, new_w;
        logic [3:0]  old_k, new_k;
        if (!rst_n) begin
            model_reset();
        end else begin
            old_w = mem[s_raddr];
            old_k = kn[s_raddr];
            new_w = old_w;
            new_k = old_k;
            if (s_rpe && s_wpe && s_raddr == s_waddr) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_wen[b]) begin
                        new_w[8*b +: 8] = s_din[8*b +: 8];
                        new_k[b] = 1'b1;
                    end
                end
            end
            if (s_wpe) begin
                for (int b = 0; b < 4; b++) begin
                    if (s_wen[b]) begin
                        mem[s_waddr][8*b +: 8] = s_din[8*b +: 8];
                        kn[s_waddr][b] = 1'b1;
                    end
                end
            end
            for (int m = 0; m < 2; m++) begin
                e_v[2+m] = p_req;
                if (p_req) begin
                    e_d[2+m] = p_d[m];
                    e_k[2+m] = p_k[m];
                end
                e_v[m] = s_rpe;
                if (s_rpe) begin
                    e_d[m] = (m == 1) ? new_w : old_w;
                    e_k[m] = (m == 1) ? &new_k : &old_k;
                end
            end
            p_req  = s_rpe;
            p_d[0] = old_w;
            p_d[1] = new_w;
            p_k    = {&new_k, &old_k};
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %08h, want %08h", name, got, want);
        end
    endtask

    task automatic check_all();
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("cfg%0d r_valid @%0t", g, $time), {31'h0, rv[g]}, {31'h0, e_v[g]});
            if (e_k[g]) chk($sformatf("cfg%0d data_out @%0t", g, $time), dout[g], e_d[g]);
        end
    endtask

    task automatic lit_all(input string name, input logic [31:0] want_rf,
                           input logic [31:0] want_wt);
        for (int g = 0; g < NCFG; g++) begin
            chk($sformatf("%s cfg%0d", name, g), dout[g], (g % 2 == 1) ? want_wt : want_rf);
        end
    endtask

    task automatic cyc(input logic wpe, input logic [3:0] wen, input logic [3:0] waddr,
                       input logic [31:0] din, input logic rpe, input logic [3:0] raddr);
        s_wpe   = wpe;
        s_wen   = wen;
        s_waddr = waddr;
        s_din   = din;
        s_rpe   = rpe;
        s_raddr = raddr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        cyc(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    initial begin
        model_reset();
        idle();
        idle();
        lit_all("reset data", 32'h0, 32'h0);
        for (int g = 0; g < NCFG; g++) chk($sformatf("reset r_valid cfg%0d", g), {31'h0, rv[g]}, 32'h0);
        rst_n = 1'b1;
        idle();

        // Byte-enable write.
        cyc(1'b1, 4'hF, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0);
        cyc(1'b1, 4'h5, 4'd3, 32'h11223344, 1'b0, 4'd0);
        cyc(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd3);
        idle();
        idle();
        lit_all("byte enables", 32'hAA22CC44, 32'hAA22CC44);

        // Reset while a read is in flight.
        s_rpe   = 1'b1;
        s_raddr = 4'd3;
        @(posedge clk);
        model_step();
        #2 rst_n = 1'b0;
        model_reset();
        s_rpe = 1'b0;
        #1;
        lit_all("reset mid-read data", 32'h0, 32'h0);
        for (int g = 0; g < NCFG; g++)
            chk($sformatf("reset mid-read r_valid cfg%0d", g), {31'h0, rv[g]}, 32'h0);
        @(negedge clk);
        check_all();
        idle();
        rst_n = 1'b1;
        idle();
        idle();

        // Collision, then re-read one cycle after the write.
        cyc(1'b1, 4'hF, 4'd5, 32'h12345678, 1'b0, 4'd0);
        cyc(1'b1, 4'h3, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
        idle();
        idle();
        lit_all("collision", 32'h12345678, 32'h1234FFFF);
        cyc(1'b1, 4'hF, 4'd5, 32'h12345678, 1'b0, 4'd0);
        cyc(1'b1, 4'h3, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
        cyc(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd5);
        idle();
        idle();
        lit_all("re-read", 32'h1234FFFF, 32'h1234FFFF);

        // Streaming reads over a fully written array.
        for (int i = 0; i < 16; i++) cyc(1'b1, 4'hF, 4'(i), 32'hA5A50000 + 32'(i), 1'b0, 4'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'(i));
        idle();
        idle();
        lit_all("stream last", 32'hA5A5000F, 32'hA5A5000F);

        // Request gaps.
        cyc(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd1);
        idle();
        cyc(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd2);
        idle();
        idle();
        lit_all("gap last", 32'hA5A50002, 32'hA5A50002);

        // Address wrap: top and bottom words stay distinct.
        cyc(1'b1, 4'hF, 4'd15, 32'hCAFEF00D, 1'b0, 4'd0);
        cyc(1'b1, 4'hF, 4'd0, 32'h0BADBEEF, 1'b0, 4'd0);
        cyc(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd15);
        idle();
        idle();
        lit_all("wrap addr 15", 32'hCAFEF00D, 32'hCAFEF00D);
        cyc(1'b0, 4'h0, 4'd0, 32'h0, 1'b1, 4'd0);
        idle();
        idle();
        lit_all("wrap addr 0", 32'h0BADBEEF, 32'h0BADBEEF);

        // Random traffic with frequent same-address collisions.
        for (int n = 0; n < 1500; n++) begin
            logic [3:0] wa;
            logic [3:0] ra;
            wa = 4'($urandom_range(0, 15));
            ra = ($urandom_range(0, 3) == 0) ? wa : 4'($urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), wa, $urandom(),
                1'($urandom_range(0, 1)), ra);
        end
        idle();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
